// File: rtl/key_scan_pkg.sv
// key_scan_pkg -- shared types and helpers for the key zone scanner.
//   state_t   : scanner FSM states
//   CNT_W     : per-key dark-pixel counter width
//   MAX_KEYS  : upper bound on NUM_KEYS (sets the key index width)
//   PITCH_LOG2: log2 of the frame-buffer line pitch in pixels
//   pix_addr(): byte address of pixel (x, y) in the 16-bit-per-pixel buffer
package key_scan_pkg;

    localparam int CNT_W      = 16;
    localparam int MAX_KEYS   = 16;
    localparam int PITCH_LOG2 = 9;
    localparam int CRD_W      = 16;   // pixel coordinate / small counter width
    localparam int KEY_IDX_W  = 4;    // holds 0..MAX_KEYS-1

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GAP     = 3'd1,
        S_REQ     = 3'd2,
        S_WAIT    = 3'd3,
        S_ACCUM   = 3'd4,
        S_PUBLISH = 3'd5
    } state_t;

    function automatic logic [31:0] pix_addr(input logic [31:0]      base,
                                             input logic [CRD_W-1:0] x,
                                             input logic [CRD_W-1:0] y);
        logic [31:0] lin;
        lin = {16'd0, x} + ({16'd0, y} << PITCH_LOG2);
        return base + (lin << 1);
    endfunction

endpackage

// File: rtl/zone_accumulator.sv
// zone_accumulator -- per-key saturating dark-pixel counters plus the
// pressed/released decision and its output register.
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_clear          : zero all counters (start of frame)
//   i_inc, i_inc_k   : add one to counter i_inc_k (saturates at all-ones)
//   i_publish        : latch new key flags, flag a change if any bit moved
//   i_press_thresh   : count at which a key reads as pressed
//   o_key_pressed    : registered key flags
//   o_key_changed    : one-cycle pulse alongside a publish that changed flags
// Build option KEY_SCAN_HYSTERESIS_EN: a pressed key only releases once its
// count falls below half the press threshold.
module zone_accumulator
    import key_scan_pkg::*;
#(
    parameter int NUM_KEYS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_inc,
    input  logic [KEY_IDX_W-1:0] i_inc_k,
    input  logic                 i_publish,
    input  logic [CNT_W-1:0]     i_press_thresh,
    output logic [NUM_KEYS-1:0]  o_key_pressed,
    output logic                 o_key_changed
);

    logic [CNT_W-1:0]    r_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] r_pressed;
    logic                r_changed;
    logic [NUM_KEYS-1:0] w_next;

`ifdef KEY_SCAN_HYSTERESIS_EN
    logic [CNT_W-1:0] w_release_th;
    assign w_release_th = i_press_thresh >> 1;
`endif

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (i_reset || i_clear)
                r_cnt[k] <= '0;
            else if (i_inc && i_inc_k == KEY_IDX_W'(k) && r_cnt[k] != '1)
                r_cnt[k] <= r_cnt[k] + 1'b1;
        end
    end

    always_comb begin
        w_next = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
`ifdef KEY_SCAN_HYSTERESIS_EN
            w_next[k] = r_pressed[k] ? (r_cnt[k] >= w_release_th)
                                     : (r_cnt[k] >= i_press_thresh);
`else
            w_next[k] = (r_cnt[k] >= i_press_thresh);
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pressed <= '0;
            r_changed <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (i_publish) begin
                r_pressed <= w_next;
                r_changed <= (w_next != r_pressed);
            end
        end
    end

    assign o_key_pressed = r_pressed;
    assign o_key_changed = r_changed;

endmodule

// File: rtl/key_zone_scanner.sv
// key_zone_scanner -- Avalon read master that walks a grayscale scan band of
// the video-in frame buffer pixel by pixel, counts dark pixels per key zone
// and publishes one pressed flag per key at the end of every frame.
//   CLOCK_50, reset       : clock, synchronous active-high reset
//   enable                : run frames back to back while high
//   luma_thresh           : pixel is dark when strictly below this
//   press_thresh          : dark count at which a key reads pressed
//   bus_grant/addr/byte_enable/read/ack/read_data : bridge master port
//   key_pressed, key_changed, frame_done, busy     : results and status
// Build option KEY_SCAN_HYSTERESIS_EN enables release hysteresis (see
// zone_accumulator).
module key_zone_scanner
    import key_scan_pkg::*;
#(
    parameter int          NUM_KEYS   = 8,
    parameter int          KEY_WIDTH  = 40,
    parameter int          X_START    = 0,
    parameter int          ROW_START  = 200,
    parameter int          ROW_END    = 239,
    parameter logic [31:0] BASE_ADDR  = 32'h0800_0000,
    parameter int          GAP_CYCLES = 3
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                enable,
    input  logic [7:0]          luma_thresh,
    input  logic [15:0]         press_thresh,
    input  logic                bus_grant,
    output logic [31:0]         bus_addr,
    output logic [3:0]          bus_byte_enable,
    output logic                bus_read,
    input  logic                bus_ack,
    input  logic [31:0]         bus_read_data,
    output logic [NUM_KEYS-1:0] key_pressed,
    output logic                key_changed,
    output logic                frame_done,
    output logic                busy
);

    localparam logic [CRD_W-1:0]     XI_LAST  = CRD_W'(KEY_WIDTH - 1);
    localparam logic [KEY_IDX_W-1:0] K_LAST   = KEY_IDX_W'(NUM_KEYS - 1);
    localparam logic [CRD_W-1:0]     X_FIRST  = CRD_W'(X_START);
    localparam logic [CRD_W-1:0]     Y_FIRST  = CRD_W'(ROW_START);
    localparam logic [CRD_W-1:0]     Y_LAST   = CRD_W'(ROW_END);
    localparam logic [CRD_W-1:0]     GAP_LAST = CRD_W'(GAP_CYCLES);

    state_t               r_state;
    logic [CRD_W-1:0]     r_xi, r_x, r_y, r_gap;
    logic [KEY_IDX_W-1:0] r_k;
    logic [7:0]           r_pix;
    logic [31:0]          r_bus_addr;
    logic                 r_bus_read;
    logic                 r_frame_done;

    logic w_last_pix, w_dark, w_unused_data;

    assign w_last_pix    = (r_xi == XI_LAST) && (r_k == K_LAST) && (r_y == Y_LAST);
    assign w_dark        = (r_pix < luma_thresh);
    assign w_unused_data = ^bus_read_data[31:8];

    // Enable is honoured only where no read is in flight (GAP, REQ before
    // issue, after the ack); bus_read is therefore never withdrawn early.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_bus_read   <= 1'b0;
            r_bus_addr   <= '0;
            r_frame_done <= 1'b0;
            r_xi         <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_k          <= '0;
            r_gap        <= '0;
            r_pix        <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: if (enable) begin
                    r_xi    <= '0;
                    r_k     <= '0;
                    r_x     <= X_FIRST;
                    r_y     <= Y_FIRST;
                    r_gap   <= '0;
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    if (!enable)                r_state <= S_IDLE;
                    else if (r_gap == GAP_LAST) r_state <= S_REQ;
                    else                        r_gap   <= r_gap + 1'b1;
                end
                S_REQ: begin
                    if (!enable) r_state <= S_IDLE;
                    else if (bus_grant) begin
                        r_bus_addr <= pix_addr(BASE_ADDR, r_x, r_y);
                        r_bus_read <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: if (bus_ack) begin
                    r_bus_read <= 1'b0;
                    r_pix      <= bus_read_data[7:0];
                    r_state    <= enable ? S_ACCUM : S_IDLE;
                end
                S_ACCUM: begin
                    r_gap <= '0;
                    if (!enable)        r_state <= S_IDLE;
                    else if (w_last_pix) r_state <= S_PUBLISH;
                    else begin
                        r_state <= S_GAP;
                        // x walks linearly across the band; xi/k/y only
                        // track zone and row boundaries.
                        if (r_xi == XI_LAST) begin
                            r_xi <= '0;
                            if (r_k == K_LAST) begin
                                r_k <= '0;
                                r_x <= X_FIRST;
                                r_y <= r_y + 1'b1;
                            end else begin
                                r_k <= r_k + 1'b1;
                                r_x <= r_x + 1'b1;
                            end
                        end else begin
                            r_xi <= r_xi + 1'b1;
                            r_x  <= r_x + 1'b1;
                        end
                    end
                end
                S_PUBLISH: begin
                    r_frame_done <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    zone_accumulator #(.NUM_KEYS(NUM_KEYS)) u_acc (
        .i_clk          (CLOCK_50),
        .i_reset        (reset),
        .i_clear        (r_state == S_IDLE && enable),
        .i_inc          (r_state == S_ACCUM && w_dark),
        .i_inc_k        (r_k),
        .i_publish      (r_state == S_PUBLISH),
        .i_press_thresh (press_thresh),
        .o_key_pressed  (key_pressed),
        .o_key_changed  (key_changed)
    );

    assign bus_addr        = r_bus_addr;
    assign bus_read        = r_bus_read;
    assign bus_byte_enable = 4'b0001;
    assign frame_done      = r_frame_done;
    assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_key_zone_scanner.sv
module tb_key_zone_scanner;
    localparam int NK = 8, KW = 5, XS = 3, RS = 200, RE = 202, GAP = 3;
    localparam logic [31:0] BASE = 32'h0800_0000;
    localparam int ROWS = RE - RS + 1, NPR = NK * KW, NPIX = ROWS * NPR;

    logic clk = 0, reset = 1, enable = 0;
    logic [7:0] luma = 0;
    logic [15:0] pth = 0;
    logic grant = 0, ack_m = 0, ack_x = 0, bus_ack;
    logic [31:0] rdata = 0, bus_addr;
    logic [3:0] bus_byte_enable;
    logic bus_read, key_changed, frame_done, busy;
    logic [NK-1:0] key_pressed;

    assign bus_ack = ack_m | ack_x;
    always #10 clk = ~clk;

    key_zone_scanner #(.NUM_KEYS(NK), .KEY_WIDTH(KW), .X_START(XS), .ROW_START(RS),
                       .ROW_END(RE), .BASE_ADDR(BASE), .GAP_CYCLES(GAP)) dut (
        .CLOCK_50(clk), .reset(reset), .enable(enable), .luma_thresh(luma),
        .press_thresh(pth), .bus_grant(grant), .bus_addr(bus_addr),
        .bus_byte_enable(bus_byte_enable), .bus_read(bus_read), .bus_ack(bus_ack),
        .bus_read_data(rdata), .key_pressed(key_pressed), .key_changed(key_changed),
        .frame_done(frame_done), .busy(busy));

    int checks = 0, fails = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Frame image: img[row][col] is pixel (XS+col, RS+row).
    logic [7:0] img [ROWS][NPR];
    logic [NK-1:0] exp_kp = '0;

    function automatic logic [31:0] exp_addr(input int idx);
        int x, y;
        x = XS + idx % NPR;
        y = RS + idx / NPR;
        return BASE + 32'((x + (y << 9)) << 1);
    endfunction

    // Bridge / arbiter model and protocol monitor.
    bit hold = 0, grant_rand = 0, spur = 0, zw = 0, rst_exc = 0;
    int dly_lo = 0, dly_hi = 0;
    bit prev_read = 0, pending = 0, rise_ok = 0;
    int wait_cnt = 0, exp_idx = 0, nreads = 0, fd_cnt = 0, kc_cnt = 0, cyc = 0, last_rise = 0;
    int req_row = 0, req_col = 0;
    logic [31:0] req_addr = 0, r32;

    always @(negedge clk) begin
        cyc++;
        if (frame_done) fd_cnt++;
        if (key_changed) kc_cnt++;
        if (!zw || !enable || reset) rise_ok = 0;
        if (bus_read && prev_read && !rst_exc) chk("addr_stable", bus_addr, req_addr);
        if (prev_read && !bus_read && !rst_exc) begin
            chk("rd_until_ack", bus_ack, 1);
            chk("addr_after_ack", bus_addr, req_addr);
        end
        if (bus_read && !prev_read) begin
            chk("grant", grant, 1);
            chk("addr", bus_addr, exp_addr(exp_idx));
            chk("be", bus_byte_enable, 4'b0001);
            if (zw) begin
                if (rise_ok) chk("pix_cycles", cyc - last_rise, (exp_idx == 0) ? GAP + 6 : GAP + 4);
                last_rise = cyc;
                rise_ok = 1;
            end
            req_row = exp_idx / NPR;
            req_col = exp_idx % NPR;
            req_addr = bus_addr;
            exp_idx = (exp_idx + 1) % NPIX;
            nreads++;
            pending = 1;
            wait_cnt = $urandom_range(dly_hi, dly_lo);
        end
        ack_m = 0;
        if (!bus_read) pending = 0;
        if (pending && !hold) begin
            if (wait_cnt == 0) begin
                r32 = $urandom();
                rdata = {r32[31:8], img[req_row][req_col]};
                ack_m = 1;
                pending = 0;
            end else wait_cnt--;
        end else if (!bus_read && spur && ($urandom_range(0, 3) == 0)) ack_m = 1;
        if (!busy) exp_idx = 0;
        grant = grant_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        prev_read = bus_read;
    end

    // One frame: build image/thresholds, predict flags, wait for publish.
    task automatic frame(input int mode, input int n);
        int cnt[NK];
        int d[NK];
        logic [NK-1:0] nxt;
        int to, lt;
        case (mode)
            0: begin luma = 64; pth = 10;
                for (int r = 0; r < ROWS; r++) for (int c = 0; c < NPR; c++) img[r][c] = 8'd0; end
            1: begin luma = 64; pth = 10;
                for (int r = 0; r < ROWS; r++) for (int c = 0; c < NPR; c++)
                    img[r][c] = (c / KW == 3) ? 8'd10 : 8'd200; end
            3: begin luma = 100; pth = 10;
                for (int r = 0; r < ROWS; r++) for (int c = 0; c < NPR; c++)
                    img[r][c] = (c < KW && r * KW + c < n) ? 8'd0 : 8'd255; end
            default: begin
                lt = $urandom_range(1, 255);
                luma = 8'(lt);
                pth = 16'($urandom_range(0, 16));
                for (int k = 0; k < NK; k++) d[k] = $urandom_range(0, 100);
                for (int r = 0; r < ROWS; r++) for (int c = 0; c < NPR; c++)
                    img[r][c] = ($urandom_range(0, 99) < d[c / KW]) ? 8'($urandom_range(0, lt - 1))
                                                                  : 8'($urandom_range(lt, 255));
            end
        endcase
        for (int k = 0; k < NK; k++) cnt[k] = 0;
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < NPR; c++)
            if (img[r][c] < luma) cnt[c / KW]++;
        for (int k = 0; k < NK; k++) begin
`ifdef KEY_SCAN_HYSTERESIS_EN
            nxt[k] = exp_kp[k] ? (cnt[k] >= int'(pth >> 1)) : (cnt[k] >= int'(pth));
`else
            nxt[k] = (cnt[k] >= int'(pth));
`endif
        end
        enable = 1;
        to = 0;
        while (!frame_done && to < 20000) begin @(negedge clk); to++; end
        chk("fd_timeout", frame_done, 1);
        if (frame_done) begin
            chk("key_pressed", key_pressed, nxt);
            chk("key_changed", key_changed, nxt != exp_kp);
            if (mode == 0) chk("all_black", key_pressed, 8'hFF);
            if (mode == 1) chk("zone3", key_pressed, 8'h08);
            exp_kp = nxt;
            @(negedge clk);
            chk("fd_pulse", frame_done, 0);
            chk("kc_pulse", key_changed, 0);
        end
    endtask

    initial begin
        int to, fd0, kc0;
        logic [NK-1:0] kp0;
        repeat (3) @(negedge clk);
        chk("rst_read", bus_read, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_be", bus_byte_enable, 4'b0001);
        chk("rst_kp", key_pressed, 0);
        chk("rst_kc", key_changed, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_busy", busy, 0);
        reset = 0;
        @(negedge clk);

        zw = 1;
        frame(0, 0);
        frame(1, 0);
        zw = 0; grant_rand = 1; spur = 1; dly_lo = 0; dly_hi = 3;
        repeat (5) frame(2, 0);
        grant_rand = 0; spur = 0; dly_hi = 0;
        frame(3, 12); frame(3, 7); frame(3, 4);
        grant_rand = 1; dly_lo = 20; dly_hi = 20;
        frame(2, 0);

        // Drop enable while a read is outstanding.
        grant_rand = 0; dly_lo = 8; dly_hi = 8;
        fd0 = fd_cnt; kc0 = kc_cnt; kp0 = key_pressed; to = nreads;
        while (!(nreads >= to + 5 && bus_read) && nreads < to + 1000) @(negedge clk);
        enable = 0;
        @(negedge clk);
        chk("abort_rd_held", bus_read, 1);
        to = 0;
        while (busy && to < 200) begin @(negedge clk); to++; end
        chk("abort_idle", busy, 0);
        chk("abort_kp", key_pressed, kp0);
        chk("abort_fd", fd_cnt, fd0);
        chk("abort_kc", kc_cnt, kc0);
        dly_lo = 0; dly_hi = 2;
        frame(2, 0);

        // Reset while waiting on the bridge, late ack after reset releases.
        hold = 1;
        to = 0;
        while (!bus_read && to < 200) begin @(negedge clk); to++; end
        chk("hold_read", bus_read, 1);
        @(negedge clk);
        fd0 = fd_cnt; kc0 = kc_cnt;
        rst_exc = 1; reset = 1; enable = 0;
        @(negedge clk);
        chk("rstw_read", bus_read, 0);
        reset = 0; ack_x = 1;
        @(negedge clk);
        ack_x = 0;
        repeat (3) @(negedge clk);
        chk("rstw_read2", bus_read, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_kp", key_pressed, 0);
        chk("rstw_fd", fd_cnt, fd0);
        chk("rstw_kc", kc_cnt, kc0);
        exp_kp = '0; hold = 0; rst_exc = 0;
        frame(1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/key_zone_scanner.md
# key_zone_scanner

Avalon bus-master stage downstream of the video-in frame buffer. Reads an 8-bit grayscale scan band of the captured frame through the external bus bridge and counts dark pixels in NUM_KEYS adjacent horizontal key zones. At each completed frame it publishes one pressed/released flag per piano key to the HPS-visible PIO and the audio path.

## Interface
- NUM_KEYS, 8: number of key zones (1..16).
- KEY_WIDTH, 40: zone width in pixels.
- X_START, 0: left pixel of zone 0.
- ROW_START / ROW_END, 200 / 239: inclusive scan band rows.
- BASE_ADDR, 32'h0800_0000: video-in buffer base byte address.
- GAP_CYCLES, 3: idle cycles between bus reads (bus-hogging guard).
---
- CLOCK_50  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  start and continue scanning frames.
- luma_thresh  in  8  a pixel is dark when its value is strictly below this.
- press_thresh  in  16  dark-pixel count at which a key reads as pressed.
- bus_grant  in  1  top-level arbiter grants the bridge to this block.
- bus_addr  out  32  byte address.
- bus_byte_enable  out  4  constant 4'b0001.
- bus_read  out  1  read request.
- bus_ack  in  1  bridge acknowledge.
- bus_read_data  in  32  only bits [7:0] are used.
- key_pressed  out  NUM_KEYS  registered key flags.
- key_changed  out  1  1-cycle pulse when key_pressed changes.
- frame_done  out  1  1-cycle pulse at each publish.
- busy  out  1  high in every state other than IDLE.

## Operation
- Pixel address: BASE_ADDR + ((x + (y << 9)) << 1), computed in 32 bits; x = X_START + k*KEY_WIDTH + xi.
- Coordinate tracking uses counters, with no multiply or divide:
  - xi wraps at KEY_WIDTH-1 and then increments k.
  - k wraps at NUM_KEYS-1 and then increments y.
  - y runs from ROW_START to ROW_END.
- FSM states:
  - IDLE: if enable, clear counters and go to GAP.
  - GAP: count GAP_CYCLES, then go to REQ.
  - REQ: wait for bus_grant, then drive bus_addr and set bus_read=1; go to WAIT.
  - WAIT: on bus_ack, set bus_read=0, capture data[7:0], go to ACCUM.
  - ACCUM: if pixel < luma_thresh, increment count[k], saturating at 16'hFFFF. Advance coordinates. After the last pixel go to PUBLISH, otherwise to GAP.
  - PUBLISH: compute the new key_pressed; pulse frame_done; pulse key_changed if any bit differs; go to IDLE.
- Press rule: key_pressed[k] = (count[k] >= press_thresh).
- Enable dropped mid-frame:
  - An outstanding read always completes; bus_read is never withdrawn before bus_ack.
  - After that read completes, go to IDLE, discard partial counts, and hold key_pressed.
- bus_ack is ignored in every state except WAIT.
- Thresholds are sampled in ACCUM and PUBLISH; changes take effect immediately.

## Timing
- Reset values: bus_read=0, bus_addr=0, bus_byte_enable=4'b0001, key_pressed=0, key_changed=0, frame_done=0, busy=0, state=IDLE.
- Reset mid-transaction: bus_read is low on the next edge, and any late ack is ignored.
- Per pixel with a zero-wait bridge: GAP_CYCLES+1 (GAP) + 1 (REQ) + ack latency + 1 (ACCUM).
- bus_addr is stable from REQ until the cycle after bus_ack.
- key_pressed updates on the same edge that frame_done pulses.
- When enable is held high, the next frame starts 2 cycles after PUBLISH (via IDLE).

## Configuration
- KEY_SCAN_HYSTERESIS_EN defined:
  - A pressed key releases only when count[k] < (press_thresh >> 1).
  - A released key presses when count[k] >= press_thresh.
- Macro undefined: the plain single-threshold rule applies.

## Structure
- Package key_scan_pkg holds:
  - the state enum;
  - CNT_W = 16;
  - MAX_KEYS = 16;
  - PITCH_LOG2 = 9;
  - the address function.
- Sub-module zone_accumulator holds:
  - the NUM_KEYS saturating counter bank, with clear, increment(k) and publish ports;
  - the press/hysteresis compare;
  - the key_pressed register and change detect.

## Test plan
- All-black frame (bus_read_data 0), luma_thresh 64, press_thresh 100, band 40 rows → count 1600 per key; key_pressed=8'hFF; one key_changed pulse.
- Zone 3 dark only (pixel 10), all others 200 → key_pressed=8'h08 after frame_done.
- Addresses: first read 32'h0800_0000 + ((0 + (200<<9))<<1) = 32'h0803_2000; last read uses x=319, y=239.
- Ack delayed 20 cycles with bus_grant toggling → bus_read held until ack, read never issued without grant, counts unchanged.
- Reset asserted in WAIT, with ack the following cycle → bus_read=0, state IDLE, key_pressed=0, no pulses.
- KEY_SCAN_HYSTERESIS_EN, press_thresh 100:
  - frames with count 120, 70, 40 on key 0 → key_pressed[0] = 1, 1, 0;
  - without the macro → 1, 0, 0.
